// File: rtl/calc_pkg.sv
// Shared types, ASCII constants and key decoding for the calculator keypad controller.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_A,
        ST_B,
        ST_MUL,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_DIGIT,
        KEY_OP,
        KEY_CLEAR,
        KEY_EQ
    } key_kind_t;

    // Digits carry their numeric value; operators carry their ASCII character.
    typedef struct packed {
        key_kind_t  kind;
        logic [7:0] value;
    } key_t;

    localparam logic [7:0]  CH_ZERO  = 8'h30;
    localparam logic [7:0]  CH_PLUS  = 8'h2B;
    localparam logic [7:0]  CH_MINUS = 8'h2D;
    localparam logic [7:0]  CH_STAR  = 8'h2A;
    localparam logic [15:0] SAT_MAX  = 16'hFFFF;

    function automatic key_t decode_key(input logic [1:0] row, input logic [1:0] col);
        key_t k;
        k.kind  = KEY_NONE;
        k.value = 8'd0;
        if (row == 2'd3) begin
            case (col)
                2'd0:    k.kind = KEY_CLEAR;
                2'd1:    k.kind = KEY_DIGIT;
                2'd2:    k.kind = KEY_EQ;
                default: k.kind = KEY_NONE;
            endcase
        end else if (col == 2'd3) begin
            k.kind = KEY_OP;
            case (row)
                2'd0:    k.value = CH_PLUS;
                2'd1:    k.value = CH_MINUS;
                default: k.value = CH_STAR;
            endcase
        end else begin
            k.kind  = KEY_DIGIT;
            k.value = {6'd0, row} * 8'd3 + {6'd0, col} + 8'd1;
        end
        return k;
    endfunction

endpackage

// File: rtl/calc_if.sv
// Keypad pulses in, display-facing values out; slave is the controller, master the UI side.
interface calc_if;
    import calc_pkg::*;

    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_ok;
    logic [3:0]  cursor_x;
    logic [3:0]  cursor_y;
    logic [15:0] input_val_a;
    logic [15:0] input_val_b;
    logic [15:0] result;
    logic [7:0]  op_char;
    logic        calc_done;
    logic        busy;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_ok,
        input  cursor_x, cursor_y, input_val_a, input_val_b, result, op_char, calc_done, busy
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_ok,
        output cursor_x, cursor_y, input_val_a, input_val_b, result, op_char, calc_done, busy
    );

endinterface

// File: rtl/calc_mul16.sv
// Iterative shift-add multiplier; the first partial product is taken in the start cycle.
module calc_mul16
    import calc_pkg::*;
#(
    parameter int MUL_ITER = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [31:0] product
);

    localparam int CW = $clog2(MUL_ITER + 1);

    logic [31:0]   mcand;
    logic [31:0]   acc;
    logic [15:0]   mplier;
    logic [CW-1:0] count;
    logic          running;

    // Folding iteration one into the start cycle lets done land exactly MUL_ITER cycles later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= 32'd0;
            acc     <= 32'd0;
            mplier  <= 16'd0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc     <= b[0] ? {16'd0, a} : 32'd0;
                mcand   <= {15'd0, a, 1'b0};
                mplier  <= {1'b0, b[15:1]};
                count   <= CW'(MUL_ITER - 1);
                running <= 1'b1;
            end else if (running) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= {mcand[30:0], 1'b0};
                mplier <= {1'b0, mplier[15:1]};
                count  <= count - CW'(1);
                if (count == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator keypad sequencer: cursor, operand entry, operator and evaluation.
// Define CALC_CURSOR_WRAP_EN to make cursor moves wrap instead of clamping.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int MUL_ITER = 16
) (
    input  logic clk_in,
    input  logic sys_rst_n,
    calc_if.slave bus
);

    state_t      state, state_next;
    logic [1:0]  cx, cy, cx_next, cy_next;
    logic [15:0] a, b, res, a_next, b_next, res_next;
    logic [7:0]  op, op_next;
    logic        mul_start;
    logic        mul_done;
    logic [31:0] product;
    key_t        key;
    logic [19:0] a_app, b_app;
    logic [16:0] sum;

    // The key is decoded from the pre-move cursor so an ok coinciding with a move hits the old key.
    assign key   = decode_key(cy, cx);
    assign a_app = {4'd0, a} * 20'd10 + {16'd0, key.value[3:0]};
    assign b_app = {4'd0, b} * 20'd10 + {16'd0, key.value[3:0]};
    assign sum   = {1'b0, a} + {1'b0, b};

    always_comb begin
        cx_next = cx;
        cy_next = cy;
`ifdef CALC_CURSOR_WRAP_EN
        if (bus.btn_up)         cy_next = cy - 2'd1;
        else if (bus.btn_down)  cy_next = cy + 2'd1;
        else if (bus.btn_left)  cx_next = cx - 2'd1;
        else if (bus.btn_right) cx_next = cx + 2'd1;
`else
        if (bus.btn_up) begin
            if (cy != 2'd0) cy_next = cy - 2'd1;
        end else if (bus.btn_down) begin
            if (cy != 2'd3) cy_next = cy + 2'd1;
        end else if (bus.btn_left) begin
            if (cx != 2'd0) cx_next = cx - 2'd1;
        end else if (bus.btn_right) begin
            if (cx != 2'd3) cx_next = cx + 2'd1;
        end
`endif
    end

    always_comb begin
        state_next = state;
        a_next     = a;
        b_next     = b;
        res_next   = res;
        op_next    = op;
        mul_start  = 1'b0;
        if (state == ST_MUL) begin
            if (mul_done) begin
                res_next   = (|product[31:16]) ? SAT_MAX : product[15:0];
                state_next = ST_DONE;
            end
        end else if (bus.btn_ok) begin
            case (key.kind)
                KEY_CLEAR: begin
                    a_next     = 16'd0;
                    b_next     = 16'd0;
                    res_next   = 16'd0;
                    op_next    = 8'd0;
                    state_next = ST_A;
                end
                KEY_DIGIT: begin
                    if (state == ST_A) begin
                        if (a_app[19:16] == 4'd0) a_next = a_app[15:0];
                    end else if (state == ST_B) begin
                        if (b_app[19:16] == 4'd0) b_next = b_app[15:0];
                    end else begin
                        a_next     = {8'd0, key.value};
                        b_next     = 16'd0;
                        res_next   = 16'd0;
                        op_next    = 8'd0;
                        state_next = ST_A;
                    end
                end
                KEY_OP: begin
                    op_next    = key.value;
                    state_next = ST_B;
                    if (state == ST_DONE) begin
                        a_next = res;
                        b_next = 16'd0;
                    end
                end
                KEY_EQ: begin
                    if (state == ST_B) begin
                        if (op == CH_PLUS) begin
                            res_next   = sum[16] ? SAT_MAX : sum[15:0];
                            state_next = ST_DONE;
                        end else if (op == CH_MINUS) begin
                            res_next   = (a < b) ? 16'd0 : a - b;
                            state_next = ST_DONE;
                        end else if (op == CH_STAR) begin
                            mul_start  = 1'b1;
                            state_next = ST_MUL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!sys_rst_n) begin
            state <= ST_A;
            cx    <= 2'd0;
            cy    <= 2'd0;
            a     <= 16'd0;
            b     <= 16'd0;
            res   <= 16'd0;
            op    <= 8'd0;
        end else begin
            state <= state_next;
            cx    <= cx_next;
            cy    <= cy_next;
            a     <= a_next;
            b     <= b_next;
            res   <= res_next;
            op    <= op_next;
        end
    end

    calc_mul16 #(.MUL_ITER(MUL_ITER)) u_mul (
        .clk     (clk_in),
        .rst_n   (sys_rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    assign bus.cursor_x    = {2'b00, cx};
    assign bus.cursor_y    = {2'b00, cy};
    assign bus.input_val_a = a;
    assign bus.input_val_b = b;
    assign bus.result      = res;
    assign bus.op_char     = op;
    assign bus.calc_done   = (state == ST_DONE);
    assign bus.busy        = (state == ST_MUL);

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the 4x4 calculator keypad UI. Takes debounced one-cycle button pulses, moves the keypad cursor, and decodes the selected key into operand entry, operator selection, clear and evaluate. It owns all operand, operator and result registers, and drives the cursor, values, operator character and completion flag consumed by the LCD picture generator.

## Interface
- Parameters:
  - MUL_ITER, 16: shift-add multiplier iterations (operand width).
- Ports:
  - clk_in  in  1  system clock
  - sys_rst_n  in  1  reset. One clock; reset is synchronous and active-low.
  - btn_up / btn_down / btn_left / btn_right  in  1 each  one-cycle cursor-move pulses
  - btn_ok  in  1  one-cycle select pulse; acts on the key under the cursor
  - cursor_x, cursor_y  out  4 each  cursor column/row, 0..3
  - input_val_a, input_val_b  out  16 each  operands, unsigned
  - result  out  16  unsigned result
  - op_char  out  8  ASCII "+", "-", "*", or 0 when no operator is selected
  - calc_done  out  1  result valid; level signal
  - busy  out  1  multiply in progress

## Operation
- Key map by (row, col):
  - row 0: 1 2 3 +
  - row 1: 4 5 6 -
  - row 2: 7 8 9 *
  - row 3: C 0 = (blank)
  - (3,3) is blank and ignored.
- Direction priority: up > down > left > right. At most one move is applied per cycle.
- Edge behaviour: clamp at 0/3 (see Configuration).
- btn_ok in the same cycle as a move acts on the pre-move cursor position.
- Digit entry: new = val*10 + d, computed 20 bits wide. If new > 65535 the digit is ignored and the value is held.
- States:
  - ST_A:
    - digit appends to A
    - op key sets op_char and moves to ST_B
    - "=" is ignored
  - ST_B:
    - digit appends to B
    - op key replaces op_char
    - "=" with "+" or "-" computes and moves to ST_DONE
    - "=" with "*" moves to ST_MUL
  - ST_MUL:
    - busy=1; runs MUL_ITER shift-add iterations, then moves to ST_DONE
    - btn_ok is ignored; cursor moves are still accepted
  - ST_DONE:
    - calc_done=1
    - digit clears everything, loads A=d, and moves to ST_A
    - op key chains: A<=result, B<=0, op set, calc_done<=0, moves to ST_B
    - "=" is ignored
  - "C" in any state except ST_MUL: A=B=result=0, op_char=0, calc_done=0, moves to ST_A.
- Arithmetic:
  - add saturates at 65535
  - subtract clamps to 0 when A<B
  - multiply uses a 32-bit product, saturated to 65535

## Timing
- Reset values: cursor (0,0); A, B and result 0; op_char 0; calc_done 0; busy 0; state ST_A.
- Reset mid-multiply aborts the multiply immediately.
- Cursor, operand and op_char updates are visible on the cycle after the pulse edge.
- "+"/"-" evaluate: result and calc_done become valid 1 cycle after the btn_ok edge.
- "*" evaluate: busy rises 1 cycle after the btn_ok edge and stays high for MUL_ITER cycles. Result and calc_done become valid MUL_ITER+1 cycles after the btn_ok edge, in the same cycle busy falls.
- calc_done holds until a digit, op or "C" key leaves ST_DONE, or until reset.

## Configuration
- CALC_CURSOR_WRAP_EN:
  - Defined: cursor moves wrap modulo 4 (left from x=0 gives x=3, down from y=3 gives y=0).
  - Undefined: cursor moves clamp at 0 and 3.

## Structure
- Package calc_pkg holds:
  - state enum
  - ASCII constants for digits and operators
  - key-decode function (row, col) -> {kind, value}
  - saturation limit 16'hFFFF
- Sub-module calc_mul16: iterative shift-add multiplier with start/done handshake.
  - start is a one-cycle pulse.
  - done is a one-cycle pulse after MUL_ITER cycles, carrying the 32-bit product.

## Test plan
- Reset: assert sys_rst_n=0 for 1 cycle mid-sequence -> all outputs zero, state ST_A.
- Add: select keys 1, 2, +, 3, 4, = -> A=12, op_char="+", B=34, result=46, calc_done one cycle after the "=" press.
- Subtract clamp: 5, -, 9, = -> result=0 and calc_done=1.
- Multiply: 3, 0, 0, *, 3, 0, 0, = -> busy for 16 cycles, result=65535 (saturated), calc_done 17 cycles after the "=" press. btn_ok pulses while busy have no effect.
- Entry overflow and chaining:
  - 6, 5, 5, 3, 5 -> A=65535; a further 6 -> A stays 65535.
  - From result 46 (the Add scenario), press "-" -> A=46, B=0, op_char="-", calc_done=0.
- Cursor edges: from (0,0), pulse left, and pulse up+right together:
  - with CALC_CURSOR_WRAP_EN: left -> x=3; up+right -> y=3 only
  - without: both stay at (0,0)
